// File: rtl/dmem_responder.sv
// Word-addressed data-memory target: accepts one load/store at a time, inserts WAIT
// wait states, then returns a one-cycle ack with read data or an error flag.
module dmem_responder #(
  parameter int AW   = 6,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  // Handshake: req is the initiator's valid and is held until ack. The responder is
  // ready only while busy=0 (IDLE); a request is accepted on the first rising edge
  // where req=1 and busy=0. ack is a single-cycle completion strobe, asserted in the
  // IDLE cycle after RESP, so a req still high then is accepted as the next request.

  localparam int         DEPTH     = 1 << AW;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH] = '{default: '0};

  logic          take;
  logic          enter_resp;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic          cur_err;
  logic [AW-1:0] idx;

  // With no wait states the acceptance edge is also the commit edge, so the live
  // request fields are used; otherwise the latched copy is.
  always_comb begin
    take       = (state == S_IDLE) && req;
    enter_resp = (WAIT == 0) ? take : ((state == S_WAIT) && (cnt == WAIT_LAST));
    cur_we     = (WAIT == 0) ? we    : lat_we;
    cur_addr   = (WAIT == 0) ? addr  : lat_addr;
    cur_wdata  = (WAIT == 0) ? wdata : lat_wdata;
    cur_be     = (WAIT == 0) ? be    : lat_be;
    cur_err    = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);
    idx        = cur_addr[AW+1:2];
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      ack <= (state == S_RESP);
      if (ack) begin
        err   <= 1'b0;
        rdata <= 32'd0;
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_be    <= be;
            cnt       <= 4'd0;
            state     <= (WAIT == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == WAIT_LAST) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        err   <= cur_err;
        rdata <= (!cur_we && !cur_err) ? mem[idx] : 32'd0;
      end
    end
  end

  // No reset here: the array survives rst, and a clock edge during rst must not commit.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_we && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the target end of the processor's load/store request interface.
- Accepts one request at a time from the datapath's memory stage.
- Inserts a programmable number of wait states, then completes with a one-cycle ack carrying read data or an error flag.
- Gives the multicycle/stalling control path a realistic memory to handshake against.

Parameters:
AW, 6, log2 of memory depth in 32-bit words (64 words)
WAIT, 2, wait-state cycles between acceptance and ack (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  1  request valid from initiator
we  input  1  1 = store, 0 = load
addr  input  32  byte address
wdata  input  32  store data
be  input  4  byte enables; be[i] selects bits 8i+7:8i
busy  output  1  high whenever not in IDLE
ack  output  1  one-cycle completion strobe
err  output  1  error status, valid only while ack=1
rdata  output  32  load data, valid only while ack=1

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - While rst is high: state=IDLE, wait counter=0, ack=0, err=0, rdata=0, busy=0.
  - Memory array is zero-initialised at time 0 only and is NOT cleared by rst.
- All outputs are registered or decoded directly from the state register; there is no combinational path from any input to any output.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req=1 at a rising edge accepts the request: addr, we, wdata, be are latched.
  - Next state is WAIT with counter=0 if WAIT>0, else RESP.
  - req=0 stays in IDLE.
- WAIT:
  - Counter increments each edge.
  - When counter==WAIT-1, next state is RESP.
  - Inputs are ignored.
- RESP: lasts exactly one cycle; next state is always IDLE. req during RESP is ignored (not queued).
- Latency: if the request is accepted at edge N, ack is high from edge N+WAIT+1 to edge N+WAIT+2.
  - The earliest next acceptance is edge N+WAIT+2.
  - Throughput is one request per WAIT+2 cycles.
- Error check uses the latched address:
  - err=1 if addr[1:0]!=0 or addr[31:AW+2]!=0.
  - On error: no memory write, rdata=0, ack still asserted.
- Load, no error: rdata = mem[addr[AW+1:2]], registered on the edge entering RESP. be is ignored for loads.
- Store, no error:
  - Each byte lane with be[i]=1 is written on the edge entering RESP; other lanes keep their value.
  - be=4'b0000 completes normally with no change.
  - rdata=0 on store acks.
- Store followed by load to the same word returns the new data; no stale read, because the write commits before the next acceptance.
- Reset mid-operation (WAIT or RESP):
  - Return immediately to IDLE with ack/err/rdata=0.
  - A store not yet committed is dropped.
  - A store committed on an edge before rst rose remains in memory.
- req is sampled only in IDLE. The initiator holds req until it sees ack; a req still high in the cycle after ack is accepted as a new request.

Test Plan:
- Reset then load: rst pulse, load addr=0x00000010 -> ack one cycle, 3 cycles after acceptance (WAIT=2), rdata=0x00000000, err=0, busy high for 3 cycles.
- Store/load round trip: store addr=0x0000000C wdata=0xDEADBEEF be=1111, then load 0x0000000C -> second ack rdata=0xDEADBEEF.
- Byte enables: word holds 0xDEADBEEF; store wdata=0x11223344 be=0101 -> load returns 0xDE22BE44. Store with be=0000 -> word unchanged.
- Errors: load addr=0x00000102 (misaligned) -> ack with err=1, rdata=0. Store addr=0x00000100 (beyond 64 words) -> err=1, and a load of 0x00000000 is unchanged.
- Back-to-back and timing:
  - req held high for 3 requests -> acks spaced exactly 4 cycles apart (WAIT=2).
  - Rebuilt with WAIT=0: ack on the edge after acceptance, spacing 2 cycles.
- Reset mid-op: store accepted, rst asserted during WAIT -> ack never fires, outputs 0, target word keeps its old value. A subsequent load completes normally.
